vga_port_arbiter: RTL and testbench

// Shares the single VGA adapter pixel-write port among the hangman drawing engines
// (clear, dash, graph, fill, parts), which otherwise contend for one x/y/colour bus.

---
 rtl/vga_port_arbiter_pkg.sv | 30 +++
 rtl/vga_port_arbiter_rr_pick.sv | 30 +++
 rtl/vga_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_vga_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_port_arbiter_pkg.sv
// Shared VGA constants for the hangman drawing engines and the pixel-port arbiter.
// Holds screen/colour widths, colour codes, requester indices and the round-robin wrap helper.
package vga_port_arbiter_pkg;

    localparam int VGA_XW    = 8;
    localparam int VGA_YW    = 7;
    localparam int VGA_CW    = 3;
    localparam int ARB_N_REQ = 5;
    localparam int ARB_IDW   = 3;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] WHITE = 3'b111;

    localparam int REQ_CLEAR = 0;
    localparam int REQ_DASH  = 1;
    localparam int REQ_GRAPH = 2;
    localparam int REQ_FILL  = 3;
    localparam int REQ_PARTS = 4;

    // Next round-robin start after an owner releases; index 0 never enters the rotation.
    function automatic logic [ARB_IDW-1:0] rr_next(input logic [ARB_IDW-1:0] id,
                                                   input int n_req);
        if (int'(id) >= n_req - 1) return ARB_IDW'(1);
        return id + ARB_IDW'(1);
    endfunction

endpackage

// File: rtl/vga_port_arbiter_rr_pick.sv
// Combinational round-robin picker over requesters 1..N_REQ-1, starting at rr_ptr_i.
// req_i bit k corresponds to requester k+1.
module vga_port_arbiter_rr_pick
    import vga_port_arbiter_pkg::*;
#(
    parameter int N_REQ = ARB_N_REQ
) (
    input  logic [N_REQ-2:0]   req_i,
    input  logic [ARB_IDW-1:0] rr_ptr_i,
    output logic [ARB_IDW-1:0] idx_o,
    output logic               found_o
);

    always_comb begin
        int cand;
        cand    = 0;
        idx_o   = '0;
        found_o = 1'b0;
        for (int k = 0; k < N_REQ - 1; k++) begin
            cand = (int'(rr_ptr_i) - 1 + k) % (N_REQ - 1) + 1;
            for (int i = 1; i < N_REQ; i++) begin
                if (!found_o && cand == i && req_i[i-1]) begin
                    found_o = 1'b1;
                    idx_o   = ARB_IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/vga_port_arbiter.sv
// Shares the single vga_adapter pixel-write port among the drawing engines, one burst per grant.
// Engine 0 (clear) has priority, the rest rotate; a watchdog reclaims the port from a stalled owner.
module vga_port_arbiter
    import vga_port_arbiter_pkg::*;
#(
    parameter int N_REQ   = ARB_N_REQ,
    parameter int XW      = VGA_XW,
    parameter int YW      = VGA_YW,
    parameter int CW      = VGA_CW,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      valid,
    input  logic [N_REQ-1:0]      last,
    input  logic [N_REQ*XW-1:0]   x_in,
    input  logic [N_REQ*YW-1:0]   y_in,
    input  logic [N_REQ*CW-1:0]   c_in,
    output logic [N_REQ-1:0]      gnt,
    output logic                  plot,
    output logic [XW-1:0]         x,
    output logic [YW-1:0]         y,
    output logic [CW-1:0]         colour,
    output logic                  busy,
    output logic                  to_err,
    output logic [ARB_IDW-1:0]    to_id
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_REL  = 2'd2
    } arb_state_e;

    arb_state_e         state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [ARB_IDW-1:0] owner_q, owner_d;
    logic [ARB_IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [WDW-1:0]     wdog_q, wdog_d;
    logic               plot_q, plot_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [CW-1:0]      c_q, c_d;
    logic               to_err_q, to_err_d;
    logic [ARB_IDW-1:0] to_id_q, to_id_d;

    logic [ARB_IDW-1:0] pick_idx;
    logic               pick_found;

    logic               own_req, own_valid, own_last;
    logic [XW-1:0]      own_x;
    logic [YW-1:0]      own_y;
    logic [CW-1:0]      own_c;
    logic               done, abort, tout;

    vga_port_arbiter_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req_i    (req[N_REQ-1:1]),
        .rr_ptr_i (rr_ptr_q),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    always_comb begin
        own_req   = 1'b0;
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_x     = '0;
        own_y     = '0;
        own_c     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == ARB_IDW'(i)) begin
                own_req   = req[i];
                own_valid = valid[i];
                own_last  = last[i];
                own_x     = x_in[i*XW +: XW];
                own_y     = y_in[i*YW +: YW];
                own_c     = c_in[i*CW +: CW];
            end
        end
    end

    // Completion outranks abort, which outranks the watchdog, when they coincide.
    assign done  = own_valid && own_last;
    assign abort = !own_req;
    assign tout  = (wdog_q == WDW'(TIMEOUT));

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        wdog_d   = wdog_q;
        plot_d   = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        c_d      = c_q;
        to_err_d = 1'b0;
        to_id_d  = to_id_q;

        case (state_q)
            ST_IDLE: begin
                if (req[0] || pick_found) begin
                    owner_d = req[0] ? '0 : pick_idx;
                    for (int i = 0; i < N_REQ; i++) begin
                        gnt_d[i] = (owner_d == ARB_IDW'(i));
                    end
                    wdog_d  = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (own_valid && (own_req || own_last)) begin
                    plot_d = 1'b1;
                    x_d    = own_x;
                    y_d    = own_y;
                    c_d    = own_c;
                end
                if (own_valid)  wdog_d = '0;
                else if (!tout) wdog_d = wdog_q + WDW'(1);
                if (done || abort || tout) begin
                    gnt_d   = '0;
                    state_d = ST_REL;
                    if (owner_q != '0) rr_ptr_d = rr_next(owner_q, N_REQ);
                    if (!done && !abort) begin
                        to_err_d = 1'b1;
                        to_id_d  = owner_q;
                    end
                end
            end
            ST_REL:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= ARB_IDW'(1);
            wdog_q   <= '0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            c_q      <= '0;
            to_err_q <= 1'b0;
            to_id_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            wdog_q   <= wdog_d;
            plot_q   <= plot_d;
            x_q      <= x_d;
            y_q      <= y_d;
            c_q      <= c_d;
            to_err_q <= to_err_d;
            to_id_q  <= to_id_d;
        end
    end

    assign gnt    = gnt_q;
    assign plot   = plot_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = c_q;
    assign busy   = (state_q != ST_IDLE);
    assign to_err = to_err_q;
    assign to_id  = to_id_q;

endmodule

// File: tb/tb_vga_port_arbiter.sv
// Directed bench for vga_port_arbiter: grant order, registered pixel path, release gap,
// priority without preemption, watchdog release, abort with round-robin wrap, mid-burst reset.
module tb_vga_port_arbiter;

    localparam int N  = 5;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int TO = 1023;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    req, valid, last;
    logic [N*XW-1:0] x_in;
    logic [N*YW-1:0] y_in;
    logic [N*CW-1:0] c_in;
    logic [N-1:0]    gnt;
    logic            plot, busy, to_err;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   colour;
    logic [2:0]      to_id;

    int n_vec = 0;
    int n_err = 0;

    vga_port_arbiter #(
        .N_REQ   (N),
        .XW      (XW),
        .YW      (YW),
        .CW      (CW),
        .TIMEOUT (TO)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .valid  (valid),
        .last   (last),
        .x_in   (x_in),
        .y_in   (y_in),
        .c_in   (c_in),
        .gnt    (gnt),
        .plot   (plot),
        .x      (x),
        .y      (y),
        .colour (colour),
        .busy   (busy),
        .to_err (to_err),
        .to_id  (to_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic l,
                         input int px, input int py, input int pc);
        valid[i]          = v;
        last[i]           = l;
        x_in[i*XW +: XW]  = XW'(px);
        y_in[i*YW +: YW]  = YW'(py);
        c_in[i*CW +: CW]  = CW'(pc);
    endtask

    task automatic clr();
        valid = '0;
        last  = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req    = '0;
        clr();
        x_in   = '0;
        y_in   = '0;
        c_in   = '0;
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL tb_timeout: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        int order [5];
        int w, n, o;
        order = '{1, 2, 3, 4, 1};

        // Test 1: reset state and a 3-pixel burst from engine 1
        resetn = 1'b0;
        req = '0; clr(); x_in = '0; y_in = '0; c_in = '0;
        step(); step();
        chk("rst_gnt",    32'(gnt), 0);
        chk("rst_plot",   32'(plot), 0);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_to_err", 32'(to_err), 0);
        chk("rst_to_id",  32'(to_id), 0);
        chk("rst_x",      32'(x), 0);
        chk("rst_y",      32'(y), 0);
        chk("rst_colour", 32'(colour), 0);
        resetn = 1'b1;
        req = 5'b00010;
        step();
        chk("t1_gnt",  32'(gnt), 2);
        chk("t1_plot0", 32'(plot), 0);
        drive(1, 1, 0, 10, 20, 1);
        step();
        chk("t1_p1_plot", 32'(plot), 1);
        chk("t1_p1_x", 32'(x), 10);
        chk("t1_p1_y", 32'(y), 20);
        chk("t1_p1_c", 32'(colour), 1);
        drive(1, 1, 0, 11, 20, 1);
        step();
        chk("t1_p2_plot", 32'(plot), 1);
        chk("t1_p2_x", 32'(x), 11);
        drive(1, 1, 1, 12, 20, 1);
        step();
        chk("t1_p3_plot", 32'(plot), 1);
        chk("t1_p3_x", 32'(x), 12);
        chk("t1_rel_gnt", 32'(gnt), 0);
        chk("t1_rel_busy", 32'(busy), 1);
        clr(); req = '0;
        step();
        chk("t1_gap_plot", 32'(plot), 0);
        chk("t1_gap_busy", 32'(busy), 0);
        chk("t1_hold_x", 32'(x), 12);
        step();
        chk("t1_idle_gnt", 32'(gnt), 0);

        // Test 2: four round-robin requesters, two-pixel bursts, non-owner noise ignored
        do_reset();
        req = 5'b11110;
        for (int b = 0; b < 5; b++) begin
            w = 0;
            while (gnt == '0 && w < 8) begin
                step();
                w++;
            end
            o = order[b];
            chk("t2_wait", 32'(w), 1);
            chk("t2_gnt", 32'(gnt), 32'(1) << o);
            for (int j = 0; j < N; j++) if (j != o) drive(j, 1, 1, 200, 100, 7);
            drive(o, 1, 0, 30 + 2*b, b, b + 1);
            step();
            chk("t2_p1_plot", 32'(plot), 1);
            chk("t2_p1_x", 32'(x), 32'(30 + 2*b));
            chk("t2_p1_c", 32'(colour), 32'(b + 1));
            drive(o, 1, 1, 31 + 2*b, b, b + 1);
            step();
            chk("t2_p2_plot", 32'(plot), 1);
            chk("t2_p2_x", 32'(x), 32'(31 + 2*b));
            chk("t2_rel_gnt", 32'(gnt), 0);
            clr();
            if (b == 4) req = '0;
            step();
            chk("t2_gap_plot", 32'(plot), 0);
            chk("t2_gap_busy", 32'(busy), 0);
        end

        // Test 3: clear engine waits for engine 2 to finish, then beats pending engine 3
        do_reset();
        req = 5'b00100;
        step();
        chk("t3_gnt2", 32'(gnt), 4);
        drive(2, 1, 0, 40, 41, 2);
        req[0] = 1'b1; req[3] = 1'b1;
        step();
        chk("t3_nopreempt", 32'(gnt), 4);
        chk("t3_p1_x", 32'(x), 40);
        drive(2, 1, 1, 42, 41, 2);
        step();
        chk("t3_p2_plot", 32'(plot), 1);
        chk("t3_p2_x", 32'(x), 42);
        chk("t3_rel_gnt", 32'(gnt), 0);
        clr(); req[2] = 1'b0;
        step();
        chk("t3_idle_gnt", 32'(gnt), 0);
        step();
        chk("t3_gnt0", 32'(gnt), 1);
        drive(0, 1, 1, 0, 0, 0);
        step();
        chk("t3_clr_plot", 32'(plot), 1);
        clr(); req[0] = 1'b0;
        step(); step();
        chk("t3_gnt3", 32'(gnt), 8);
        drive(3, 1, 1, 1, 2, 3);
        step();
        chk("t3_p3_x", 32'(x), 1);
        clr(); req = '0;
        step();

        // Test 4: owner 3 never sends a pixel; watchdog reclaims, engine 1 follows
        do_reset();
        req = 5'b01000;
        step();
        chk("t4_gnt3", 32'(gnt), 8);
        req[1] = 1'b1;
        n = 0;
        while (!to_err && n < 1100) begin
            step();
            n++;
        end
        chk("t4_cycles", 32'(n), 32'(TO + 1));
        chk("t4_to_id", 32'(to_id), 3);
        chk("t4_gnt0", 32'(gnt), 0);
        chk("t4_busy", 32'(busy), 1);
        chk("t4_plot", 32'(plot), 0);
        step();
        chk("t4_pulse", 32'(to_err), 0);
        chk("t4_id_hold", 32'(to_id), 3);
        chk("t4_idle", 32'(busy), 0);
        step();
        chk("t4_next", 32'(gnt), 2);
        drive(1, 1, 1, 9, 9, 1);
        step();
        clr(); req = '0;
        step(); step();
        chk("t4_id_hold2", 32'(to_id), 3);

        // Test 5: owner 4 aborts with a pixel pending; pointer wraps to 1
        do_reset();
        req = 5'b10000;
        step();
        chk("t5_gnt4", 32'(gnt), 16);
        drive(4, 1, 0, 50, 60, 4);
        step();
        chk("t5_p1_x", 32'(x), 50);
        drive(4, 1, 0, 51, 61, 4);
        req[4] = 1'b0; req[1] = 1'b1;
        step();
        chk("t5_abort_plot", 32'(plot), 0);
        chk("t5_abort_x", 32'(x), 50);
        chk("t5_abort_gnt", 32'(gnt), 0);
        chk("t5_rel_busy", 32'(busy), 1);
        clr(); req[4] = 1'b1;
        step();
        chk("t5_idle", 32'(busy), 0);
        step();
        chk("t5_wrap", 32'(gnt), 2);

        // Test 6: reset during engine 1 burst, with other engines asserting valid
        drive(4, 1, 0, 77, 77, 7);
        drive(2, 1, 1, 78, 78, 7);
        drive(1, 1, 0, 5, 6, 7);
        step();
        chk("t6_plot", 32'(plot), 1);
        chk("t6_x", 32'(x), 5);
        chk("t6_y", 32'(y), 6);
        resetn = 1'b0;
        step();
        chk("t6_rst_plot", 32'(plot), 0);
        chk("t6_rst_gnt", 32'(gnt), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_x", 32'(x), 0);
        chk("t6_rst_c", 32'(colour), 0);
        resetn = 1'b1; req = '0; clr();
        step();
        chk("t6_after_gnt", 32'(gnt), 0);
        chk("t6_after_plot", 32'(plot), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
